// File: rtl/r5p_pkg.sv
// ============================================================================
// r5p_pkg : shared types for the R5P bus fabric (arbiter owner, request bundle)
// Revision: 1.0
// ============================================================================
`default_nettype none

package r5p_pkg;

   typedef enum logic {
      ARB_IF = 1'b0,
      ARB_LS = 1'b1
   } arb_own_t;

   localparam int unsigned R5P_AW = 32;
   localparam int unsigned R5P_DW = 32;
   localparam int unsigned R5P_BW = R5P_DW / 8;

   // Request bundle for one port at the default core widths.
   typedef struct packed {
      logic                    wen;
      logic [R5P_AW-1:0]       adr;
      logic [R5P_BW-1:0]       ben;
      logic [R5P_BW-1:0][7:0]  wdt;
   } bus_req_t;

endpackage : r5p_pkg

`default_nettype wire

// File: rtl/r5p_arb_rr.sv
// ============================================================================
// r5p_arb_rr : 2-way grant logic (round-robin or fixed ls priority) with lock
// Revision: 1.0
// ============================================================================
`default_nettype none

module r5p_arb_rr
   import r5p_pkg::*;
#(
   parameter ARB = "RR"
)(
   input  logic clk,
   input  logic rst,
   input  logic req_if,
   input  logic req_ls,
   input  logic xfr,
   output logic sel_if,
   output logic sel_ls
);

   localparam logic POL_LS = (ARB == "LS");

   logic     pri;
   logic     lck_vld;
   arb_own_t lck_own;
   logic     any_req;
   logic     cnt_req;
   logic     win_ls;

   always_comb begin
      any_req = req_if | req_ls;
      cnt_req = req_if & req_ls;
      win_ls  = req_ls & (~req_if | POL_LS | pri);
      sel_if  = 1'b0;
      sel_ls  = 1'b0;
      // A stalled handshake keeps its owner until the transfer completes.
      if (lck_vld) begin
         sel_if = (lck_own == ARB_IF);
         sel_ls = (lck_own == ARB_LS);
      end else begin
         sel_ls = win_ls;
         sel_if = any_req & ~win_ls;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pri     <= 1'b1;
         lck_vld <= 1'b0;
         lck_own <= ARB_IF;
      end else begin
         if (any_req & ~xfr) begin
            lck_vld <= 1'b1;
            lck_own <= sel_ls ? ARB_LS : ARB_IF;
         end else if (xfr) begin
            lck_vld <= 1'b0;
         end
         // Priority passes to the loser; pri=1 means ls is favoured.
         if (!POL_LS && xfr && cnt_req) begin
            pri <= sel_if;
         end
      end
   end

endmodule : r5p_arb_rr

`default_nettype wire

// File: rtl/r5p_bus_arb.sv
// ============================================================================
// r5p_bus_arb : shares one memory bus between fetch and load/store requesters
// Revision: 1.0
// ============================================================================
`default_nettype none

module r5p_bus_arb
   import r5p_pkg::*;
#(
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 32,
   parameter int unsigned BW  = DW/8,
   parameter              ARB = "RR"
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                if_vld,
   input  logic [AW-1:0]       if_adr,
   output logic [BW-1:0][8-1:0] if_rdt,
   output logic                if_rdy,
   input  logic                ls_vld,
   input  logic                ls_wen,
   input  logic [AW-1:0]       ls_adr,
   input  logic [BW-1:0]       ls_ben,
   input  logic [BW-1:0][8-1:0] ls_wdt,
   output logic [BW-1:0][8-1:0] ls_rdt,
   output logic                ls_rdy,
   output logic                m_vld,
   output logic                m_wen,
   output logic [AW-1:0]       m_adr,
   output logic [BW-1:0]       m_ben,
   output logic [BW-1:0][8-1:0] m_wdt,
   input  logic [BW-1:0][8-1:0] m_rdt,
   input  logic                m_rdy
);

   logic     sel_if;
   logic     sel_ls;
   logic     xfr;
   logic     rsp_vld;
   arb_own_t rsp_own;

   assign m_vld = if_vld | ls_vld;
   assign xfr   = m_vld & m_rdy;

   r5p_arb_rr #(
      .ARB    (ARB)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req_if (if_vld),
      .req_ls (ls_vld),
      .xfr    (xfr),
      .sel_if (sel_if),
      .sel_ls (sel_ls)
   );

   // Fetch is always a full-width read.
   always_comb begin
      m_wen = 1'b0;
      m_adr = if_adr;
      m_ben = '1;
      m_wdt = '0;
      if (sel_ls) begin
         m_wen = ls_wen;
         m_adr = ls_adr;
         m_ben = ls_ben;
         m_wdt = ls_wdt;
      end
   end

   assign if_rdy = m_rdy & sel_if;
   assign ls_rdy = m_rdy & sel_ls;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_vld <= 1'b0;
         rsp_own <= ARB_IF;
      end else begin
         rsp_vld <= xfr & ~m_wen;
         if (xfr) begin
            rsp_own <= sel_ls ? ARB_LS : ARB_IF;
         end
      end
   end

   assign if_rdt = (rsp_vld && rsp_own == ARB_IF) ? m_rdt : '0;
   assign ls_rdt = (rsp_vld && rsp_own == ARB_LS) ? m_rdt : '0;

endmodule : r5p_bus_arb

`default_nettype wire

// File: tb/tb_r5p_bus_arb.sv
// ============================================================================
// tb_r5p_bus_arb : directed vectors, queued expectations, negedge monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_r5p_bus_arb;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             if_vld = 1'b0;
   logic [31:0]      if_adr = '0;
   logic             ls_vld = 1'b0;
   logic             ls_wen = 1'b0;
   logic [31:0]      ls_adr = '0;
   logic [3:0]       ls_ben = '0;
   logic [3:0][7:0]  ls_wdt = '0;
   logic [3:0][7:0]  m_rdt  = '0;
   logic             m_rdy  = 1'b0;

   logic [3:0][7:0]  rr_if_rdt, rr_ls_rdt, rr_m_wdt, lp_if_rdt, lp_ls_rdt, lp_m_wdt;
   logic             rr_if_rdy, rr_ls_rdy, rr_m_vld, rr_m_wen;
   logic             lp_if_rdy, lp_ls_rdy, lp_m_vld, lp_m_wen;
   logic [31:0]      rr_m_adr, lp_m_adr;
   logic [3:0]       rr_m_ben, lp_m_ben;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   r5p_bus_arb #(.AW(32), .DW(32), .BW(4), .ARB("RR")) dut_rr (
      .clk(clk), .rst(rst),
      .if_vld(if_vld), .if_adr(if_adr), .if_rdt(rr_if_rdt), .if_rdy(rr_if_rdy),
      .ls_vld(ls_vld), .ls_wen(ls_wen), .ls_adr(ls_adr), .ls_ben(ls_ben),
      .ls_wdt(ls_wdt), .ls_rdt(rr_ls_rdt), .ls_rdy(rr_ls_rdy),
      .m_vld(rr_m_vld), .m_wen(rr_m_wen), .m_adr(rr_m_adr), .m_ben(rr_m_ben),
      .m_wdt(rr_m_wdt), .m_rdt(m_rdt), .m_rdy(m_rdy)
   );

   r5p_bus_arb #(.AW(32), .DW(32), .BW(4), .ARB("LS")) dut_ls (
      .clk(clk), .rst(rst),
      .if_vld(if_vld), .if_adr(if_adr), .if_rdt(lp_if_rdt), .if_rdy(lp_if_rdy),
      .ls_vld(ls_vld), .ls_wen(ls_wen), .ls_adr(ls_adr), .ls_ben(ls_ben),
      .ls_wdt(ls_wdt), .ls_rdt(lp_ls_rdt), .ls_rdy(lp_ls_rdy),
      .m_vld(lp_m_vld), .m_wen(lp_m_wen), .m_adr(lp_m_adr), .m_ben(lp_m_ben),
      .m_wdt(lp_m_wdt), .m_rdt(m_rdt), .m_rdy(m_rdy)
   );

   // sel: 0 = nobody granted, 1 = fetch, 2 = load/store
   typedef struct {
      int          idx;
      bit          inst;
      bit          ifv;
      logic [31:0] ifa;
      bit          lsv;
      bit          lsw;
      logic [31:0] lsa;
      logic [3:0]  lsb;
      logic [31:0] wdt;
      bit          mrdy;
      int          sel;
      logic [31:0] eif;
      logic [31:0] els;
   } vec_t;

   vec_t exp_q[$];
   int   vec_n = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d actual %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drv(input bit inst, input bit r, input bit ifv, input logic [31:0] ifa,
                      input bit lsv, input bit lsw, input logic [31:0] lsa, input logic [3:0] lsb,
                      input logic [31:0] wdt, input bit mrdy, input logic [31:0] mrdt,
                      input int sel, input logic [31:0] eif, input logic [31:0] els);
      vec_t v;
      @(posedge clk);
      #1;
      rst = r; if_vld = ifv; if_adr = ifa; ls_vld = lsv; ls_wen = lsw;
      ls_adr = lsa; ls_ben = lsb; ls_wdt = wdt; m_rdy = mrdy; m_rdt = mrdt;
      v.idx = vec_n; v.inst = inst; v.ifv = ifv; v.ifa = ifa; v.lsv = lsv; v.lsw = lsw;
      v.lsa = lsa; v.lsb = lsb; v.wdt = wdt; v.mrdy = mrdy; v.sel = sel; v.eif = eif; v.els = els;
      exp_q.push_back(v);
      vec_n++;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         vec_t        v;
         logic        a_ifrdy, a_lsrdy, a_mvld, a_mwen;
         logic [31:0] a_madr, a_mwdt, a_ifrdt, a_lsrdt;
         logic [3:0]  a_mben;
         v = exp_q.pop_front();
         if (v.inst) begin
            a_ifrdy = lp_if_rdy; a_lsrdy = lp_ls_rdy; a_mvld = lp_m_vld; a_mwen = lp_m_wen;
            a_madr = lp_m_adr; a_mben = lp_m_ben; a_mwdt = lp_m_wdt;
            a_ifrdt = lp_if_rdt; a_lsrdt = lp_ls_rdt;
         end else begin
            a_ifrdy = rr_if_rdy; a_lsrdy = rr_ls_rdy; a_mvld = rr_m_vld; a_mwen = rr_m_wen;
            a_madr = rr_m_adr; a_mben = rr_m_ben; a_mwdt = rr_m_wdt;
            a_ifrdt = rr_if_rdt; a_lsrdt = rr_ls_rdt;
         end
         chk("m_vld",  v.idx, {31'd0, a_mvld},  {31'd0, v.ifv | v.lsv});
         chk("if_rdy", v.idx, {31'd0, a_ifrdy}, {31'd0, v.mrdy && v.sel == 1});
         chk("ls_rdy", v.idx, {31'd0, a_lsrdy}, {31'd0, v.mrdy && v.sel == 2});
         chk("if_rdt", v.idx, a_ifrdt, v.eif);
         chk("ls_rdt", v.idx, a_lsrdt, v.els);
         if (v.sel == 1) begin
            chk("m_adr", v.idx, a_madr, v.ifa);
            chk("m_wen", v.idx, {31'd0, a_mwen}, 32'd0);
            chk("m_ben", v.idx, {28'd0, a_mben}, 32'hF);
            chk("m_wdt", v.idx, a_mwdt, 32'd0);
         end else if (v.sel == 2) begin
            chk("m_adr", v.idx, a_madr, v.lsa);
            chk("m_wen", v.idx, {31'd0, a_mwen}, {31'd0, v.lsw});
            chk("m_ben", v.idx, {28'd0, a_mben}, {28'd0, v.lsb});
            chk("m_wdt", v.idx, a_mwdt, v.wdt);
         end
      end
   end

   initial begin
      //  inst rst ifv ifa        lsv lsw lsa        ben    wdt           rdy mrdt          sel eif           els
      // reset and idle
      drv(0, 1, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
      drv(0, 0, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
      // lone fetch
      drv(0, 0, 1, 32'h100,    0, 0, 32'h0,      4'hF, 32'h0,        1, 32'h0,        1, 32'h0,        32'h0);
      drv(0, 0, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        1, 32'h00000013, 0, 32'h00000013, 32'h0);
      drv(0, 0, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        32'h0);
      // round-robin contention from reset
      drv(0, 1, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
      drv(0, 0, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
      drv(0, 0, 1, 32'h0,      1, 0, 32'h400,    4'hF, 32'h0,        1, 32'h0,        2, 32'h0,        32'h0);
      drv(0, 0, 1, 32'h0,      1, 0, 32'h400,    4'hF, 32'h0,        1, 32'hA1,       1, 32'h0,        32'hA1);
      drv(0, 0, 1, 32'h0,      1, 0, 32'h400,    4'hF, 32'h0,        1, 32'hA2,       2, 32'hA2,       32'h0);
      drv(0, 0, 1, 32'h0,      1, 0, 32'h400,    4'hF, 32'h0,        1, 32'hA3,       1, 32'h0,        32'hA3);
      drv(0, 0, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        1, 32'hA4,       0, 32'hA4,       32'h0);
      // ls write stalled three cycles, fetch waiting
      drv(0, 0, 1, 32'h104,    1, 1, 32'h200,    4'h3, 32'h55AA,     0, 32'hE0,       2, 32'h0,        32'h0);
      drv(0, 0, 1, 32'h104,    1, 1, 32'h200,    4'h3, 32'h55AA,     0, 32'hE1,       2, 32'h0,        32'h0);
      drv(0, 0, 1, 32'h104,    1, 1, 32'h200,    4'h3, 32'h55AA,     0, 32'hE2,       2, 32'h0,        32'h0);
      drv(0, 0, 1, 32'h104,    1, 1, 32'h200,    4'h3, 32'h55AA,     1, 32'hE3,       2, 32'h0,        32'h0);
      drv(0, 0, 1, 32'h104,    0, 0, 32'h0,      4'hF, 32'h0,        1, 32'hE4,       1, 32'h0,        32'h0);
      drv(0, 0, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        1, 32'h13571357, 0, 32'h13571357, 32'h0);
      // write then read back-to-back
      drv(0, 0, 0, 32'h0,      1, 1, 32'h10,     4'hF, 32'h11223344, 1, 32'h0,        2, 32'h0,        32'h0);
      drv(0, 0, 0, 32'h0,      1, 0, 32'h10,     4'hF, 32'h0,        1, 32'hFFFFFFFF, 2, 32'h0,        32'h0);
      drv(0, 0, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        1, 32'hCAFEF00D, 0, 32'h0,        32'hCAFEF00D);
      // reset while a response is pending
      drv(0, 0, 1, 32'h300,    0, 0, 32'h0,      4'hF, 32'h0,        1, 32'h0,        1, 32'h0,        32'h0);
      drv(0, 1, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        1, 32'h77,       0, 32'h0,        32'h0);
      drv(0, 0, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        1, 32'h78,       0, 32'h0,        32'h0);
      // reset while fetch holds the lock; afterwards ls must win (pri=1, no lock)
      drv(0, 0, 1, 32'h304,    0, 0, 32'h0,      4'hF, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0);
      drv(0, 1, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
      drv(0, 0, 1, 32'h308,    1, 0, 32'h208,    4'hF, 32'h0,        1, 32'h0,        2, 32'h0,        32'h0);
      drv(0, 0, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        1, 32'h99,       0, 32'h0,        32'h99);
      // fixed ls priority instance: ls wins every contended cycle
      drv(1, 0, 1, 32'h500,    1, 0, 32'h600,    4'hF, 32'h0,        1, 32'h0,        2, 32'h0,        32'h0);
      drv(1, 0, 1, 32'h500,    1, 0, 32'h600,    4'hF, 32'h0,        1, 32'hB1,       2, 32'h0,        32'hB1);
      drv(1, 0, 1, 32'h500,    1, 0, 32'h600,    4'hF, 32'h0,        1, 32'hB2,       2, 32'h0,        32'hB2);
      drv(1, 0, 1, 32'h500,    1, 0, 32'h600,    4'hF, 32'h0,        1, 32'hB3,       2, 32'h0,        32'hB3);
      drv(1, 0, 0, 32'h0,      0, 0, 32'h0,      4'hF, 32'h0,        1, 32'hB4,       0, 32'h0,        32'hB4);
      repeat (2) @(negedge clk);
      #1;
      chk("queue_drained", vec_n, exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_r5p_bus_arb

`default_nettype wire

// File: doc/r5p_bus_arb.md
# r5p_bus_arb

Two-requester arbiter that shares one single-port memory bus between the R5P instruction-fetch bus and the load/store bus, for single-memory (von Neumann) systems. It sits between the core and the memory. It grants one request per cycle, holds the grant stable across a stalled handshake, and steers the one-cycle-delayed read data back to the requester that issued the read.

## Interface
Parameters:
- `AW`, 32, address width (all ports).
- `DW`, 32, data width (all ports).
- `BW`, `DW/8`, byte-enable width.
- `ARB`, "RR", arbitration policy: "RR" (round-robin) or "LS" (fixed load/store priority).

Ports:
- `clk`  input  1  clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `if_vld`  input  1  fetch request.
- `if_adr`  input  AW  fetch address.
- `if_rdt`  output  [BW-1:0][8-1:0]  fetch read data.
- `if_rdy`  output  1  fetch accepted.
- `ls_vld`  input  1  load/store request.
- `ls_wen`  input  1  write enable.
- `ls_adr`  input  AW  address.
- `ls_ben`  input  BW  byte enable.
- `ls_wdt`  input  [BW-1:0][8-1:0]  write data.
- `ls_rdt`  output  [BW-1:0][8-1:0]  read data.
- `ls_rdy`  output  1  accepted.
- `m_vld`  output  1  memory request.
- `m_wen`  output  1  memory write enable.
- `m_adr`  output  AW  memory address.
- `m_ben`  output  BW  memory byte enable.
- `m_wdt`  output  [BW-1:0][8-1:0]  memory write data.
- `m_rdt`  input  [BW-1:0][8-1:0]  memory read data.
- `m_rdy`  input  1  memory accepted.

## Operation
- **Handshake, all ports.** A transfer occurs on a cycle with `vld & rdy`. Read data is valid on the cycle after a read transfer. A requester holds `vld`, `adr`, `wen`, `ben` and `wdt` stable until `rdy`.
- **Fetch port as a master.** A fetch is always a read: `m_wen=0`, `m_ben='1`, `m_wdt=0` when fetch is selected.
- **Selection.**
  - A locked owner has precedence over everything else.
  - Otherwise a lone requester wins.
  - Otherwise, on contention, the policy decides:
    - "LS": load/store always wins.
    - "RR": priority register `pri` decides (0=fetch, 1=ls).
- **Priority update ("RR" only).** After any transfer that occurred under contention, `pri` toggles to the loser. A transfer without contention leaves `pri` unchanged.
- **Lock.**
  - Register `lck` (valid bit plus owner) is set when `m_vld & ~m_rdy`.
  - While `lck` is set, the selection is frozen to the owner.
  - `lck` is cleared on the transfer.
  - A selected master's request never moves to the other master mid-handshake.
- **Mux and gating.**
  - `m_*` carries the selected master's signals; `m_vld = if_vld | ls_vld`.
  - `if_rdy = m_rdy & sel_if`; `ls_rdy = m_rdy & sel_ls`.
  - The loser sees `rdy=0`.
- **Response steering.**
  - Register `rsp_vld`/`rsp_own` captures each read transfer (`m_vld & m_rdy & ~m_wen`).
  - On the following cycle, `m_rdt` is routed to the owner's `rdt`. The other port's `rdt` reads 0.
  - When `rsp_vld=0`, both `rdt` outputs are 0.
- **Write transfers.** Writes clear `rsp_vld` and produce no response.

## Timing
- **Reset values.**
  - Registers: `pri=1`, `lck=0`, `rsp_vld=0`, `rsp_own=0`.
  - Outputs: `if_rdy=0`, `ls_rdy=0`, `if_rdt=0`, `ls_rdt=0`.
  - `m_*` is combinational from the inputs; the requesters keep `vld` low during reset, so `m_vld=0`.
- **Latency.**
  - Request path (`vld` to `m_vld`, `m_rdy` to `rdy`) has zero cycles: combinational.
  - Read data has one cycle, through `rsp_own`; no data registering.
- **Back-to-back.** One transfer per cycle sustained. Interleaved fetch and ls reads return data to the correct owner on consecutive cycles.
- **Simultaneous events.**
  - New requests arriving while `lck` is set are ignored until the lock releases.
  - The lock release cycle and the next arbitration are the same cycle: the next selection is made in the cycle after the transfer.
- **Reset mid-operation.** Asserting `rst` during a lock or pending response clears `lck` and `rsp_vld` immediately. No stale data is delivered after reset.
- **Policy "LS".** Fetch starvation is acceptable: the core deasserts `if_vld` during loads.

## Structure
- Shared package `r5p_pkg` gets:
  - `arb_own_t` enum (`ARB_IF`, `ARB_LS`);
  - a per-port `bus_req_t` struct (`wen`, `adr`, `ben`, `wdt`).
- One natural sub-module, `r5p_arb_rr`: the 2-way round-robin/fixed grant logic holding `pri` and `lck`. Inputs are request bits and transfer; outputs are one-hot selection.
- The top level holds the muxes and the response register.

## Test plan
- **Lone requests.**
  - Stimulus: fetch only, `if_adr=0x100`, `m_rdy=1`, memory returns 0x00000013.
  - Required: `if_rdy=1` same cycle; `if_rdt=0x00000013` next cycle; `ls_rdt=0`.
- **Contention, "RR".**
  - Stimulus: both request continuously from reset, `m_rdy=1`.
  - Required: grants alternate ls, if, ls, if; `pri` toggles each cycle; `rdt` is steered to the alternating owner.
- **Lock.**
  - Stimulus: ls write to 0x200 with `m_rdy=0` for 3 cycles, fetch requesting throughout.
  - Required: `m_adr` stays 0x200 with `m_wen=1` for all 4 cycles; `if_rdy=0`; fetch is granted on cycle 5; no response is generated for the write.
- **Policy "LS".**
  - Stimulus: both request for 4 cycles.
  - Required: ls wins all 4; `if_rdy=0` throughout.
- **Reset mid-operation.**
  - Stimulus: lock active and `rsp_vld=1`, then assert `rst`.
  - Required: `lck=0`, `rsp_vld=0`, both `rdt=0` immediately; `pri=1` after release.
- **Write then read back-to-back.**
  - Stimulus: ls write to 0x10 followed next cycle by an ls read of 0x10 returning 0xCAFEF00D.
  - Required: `ls_rdt=0xCAFEF00D` exactly one cycle after the read transfer, and 0 in the cycle following the write.
